// File: rtl/bus_read_ctrl.sv
// Read-side bus controller: accepts upstream read requests, runs the as/ds/da handshake
// toward the bus manager and returns captured data or a timeout error downstream.
module bus_read_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as,
    output logic              bus_rw,
    output logic              bus_ds,
    input  logic              bus_da,
    input  logic [DATA_W-1:0] bus_data,
    output logic [7:0]        err_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TLast = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StRel, StResp} state_e;

    state_e            state_q;
    logic [TW-1:0]     timer_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] addr_q;
    logic              as_q;
    logic              rw_q;
    logic              ds_q;
    logic [7:0]        err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            addr_q      <= '0;
            as_q        <= 1'b0;
            rw_q        <= 1'b0;
            ds_q        <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // req_ready is low on the first edge after reset, so no handshake then
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        req_ready_q <= 1'b0;
                        as_q        <= 1'b1;
                        rw_q        <= 1'b1;
                        state_q     <= StAddr;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                StAddr: begin
                    ds_q    <= 1'b1;
                    timer_q <= '0;
                    state_q <= StData;
                end
                StData: begin
                    if (bus_da) begin
                        rsp_data_q <= bus_data;
                        rsp_err_q  <= 1'b0;
                        as_q       <= 1'b0;
                        rw_q       <= 1'b0;
                        ds_q       <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= StRel;
                    end else if (timer_q == TLast) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        err_cnt_q  <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                        as_q       <= 1'b0;
                        rw_q       <= 1'b0;
                        ds_q       <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= StRel;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StRel: begin
                    if (!bus_da) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (timer_q == TLast) begin
                        // Stuck acknowledge; count it only if DATA did not already time out
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        if (!rsp_err_q && err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign bus_addr  = addr_q;
    assign bus_as    = as_q;
    assign bus_rw    = rw_q;
    assign bus_ds    = ds_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bus_read_ctrl.sv
// Scoreboard bench for bus_read_ctrl: a reactive bus-manager model plus randomized requests;
// expected responses are computed from handshake timing rules and checked by a monitor.
module tb_bus_read_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int T = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] bus_addr;
    logic          bus_as;
    logic          bus_rw;
    logic          bus_ds;
    logic          bus_da = 1'b0;
    logic [DW-1:0] bus_data = '0;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    bus_read_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .bus_addr (bus_addr),
        .bus_as   (bus_as),
        .bus_rw   (bus_rw),
        .bus_ds   (bus_ds),
        .bus_da   (bus_da),
        .bus_data (bus_data),
        .err_cnt  (err_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            dsc;
        logic [7:0]    ecnt;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Manager model controls
    int            m_d = 0;
    int            m_hold = 0;
    logic [DW-1:0] m_data = '0;
    int            m_cnt = 0;
    int            m_hcnt = 0;

    // Monitor state
    int            mcyc = 0;
    int            acc_cyc = 0;
    int            ds_cnt = 0;
    int            as_cnt = 0;
    bit            seen = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    int            ecnt_m = 0;
    int            rr_mode = 0;
    int            bp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus manager: asserts da after m_d DATA cycles, holds it m_hold extra cycles after ds drops
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            bus_da = 1'b0;
            m_cnt  = 0;
            m_hcnt = 0;
        end else if (bus_ds && !bus_da) begin
            if (m_cnt == m_d) begin
                bus_da   = 1'b1;
                bus_data = m_data;
            end else begin
                bus_data = 16'($urandom);
            end
            m_cnt++;
            m_hcnt = 0;
        end else if (bus_da) begin
            bus_data = 16'($urandom);
            if (m_hcnt >= m_hold || rsp_valid) bus_da = 1'b0;
            else m_hcnt++;
        end else begin
            m_cnt    = 0;
            bus_data = 16'($urandom);
        end
    end

    // Response-side ready: 0 tied high, 1 random, 2 low for 10 cycles of each response
    initial forever begin
        @(negedge clk);
        if (rr_mode == 0) begin
            rsp_ready = 1'b1;
        end else if (rr_mode == 1) begin
            rsp_ready = ($urandom_range(0, 2) != 0);
        end else if (rsp_valid) begin
            if (bp_cnt < 10) begin
                rsp_ready = 1'b0;
                bp_cnt++;
            end else begin
                rsp_ready = 1'b1;
            end
        end else begin
            rsp_ready = 1'b0;
            bp_cnt    = 0;
        end
    end

    // Monitor: samples 1 time unit after each falling edge
    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        mcyc++;
        if (rst) begin
            if (req_valid && req_ready) begin
                acc_cyc = mcyc + 1;
                ds_cnt  = 0;
                as_cnt  = 0;
            end
            if (bus_as) as_cnt++;
            if (bus_ds) begin
                ds_cnt++;
                if (ds_cnt == 1) check("bus_addr", 32'(bus_addr), 32'(cur_addr));
                check("as_rw_with_ds", 32'({bus_as, bus_rw}), 32'(2'b11));
            end
            if (rsp_valid) begin
                check("req_ready_in_resp", 32'(req_ready), 32'(0));
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got data=%0h err=%0b expected none",
                             rsp_data, rsp_err);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1'b1;
                        check("latency", 32'(mcyc - acc_cyc), 32'(e.lat));
                        check("ds_cycles", 32'(ds_cnt), 32'(e.dsc));
                        check("as_cycles", 32'(as_cnt), 32'(e.dsc + 1));
                        check("err_cnt", 32'(err_cnt), 32'(e.ecnt));
                    end
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at a falling edge once the response is consumed
    task automatic txn(input logic [AW-1:0] a, input int d, input int h, input logic [DW-1:0] dat,
                       input bit keep);
        exp_t e;
        int   dc;
        int   rc;
        int   n;
        m_d = d;
        m_hold = h;
        m_data = dat;
        cur_addr = a;
        if (d < T) begin
            dc = d + 1;
            if (h >= T) begin
                rc = T;
                e.err = 1'b1;
                e.data = '0;
            end else begin
                rc = h + 1;
                e.err = 1'b0;
                e.data = dat;
            end
        end else begin
            dc = T;
            rc = 1;
            e.err = 1'b1;
            e.data = '0;
        end
        if (e.err && ecnt_m < 255) ecnt_m++;
        e.ecnt = 8'(ecnt_m);
        e.lat = 1 + dc + rc;
        e.dsc = dc;
        sb.push_back(e);
        req_addr = a;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: got no response for addr %0h expected one", a);
            sb.delete();
            seen = 1'b0;
        end
    endtask

    initial begin
        int d;
        int h;
        int r;
        int n;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_bus_rw", 32'(bus_rw), 32'(0));
        check("rst_err_cnt", 32'(err_cnt), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'(1));

        rr_mode = 0;
        txn(8'h3C, 0, 0, 16'hBEEF, 1'b0);
        txn(8'h5A, 5, 0, 16'h1234, 1'b0);
        check("slow_err_cnt", 32'(err_cnt), 32'(0));
        txn(8'h77, 30, 0, 16'hAAAA, 1'b0);

        rr_mode = 2;
        txn(8'h10, 1, 0, 16'hCAFE, 1'b1);
        rr_mode = 0;
        txn(8'h11, 0, 0, 16'h0F0F, 1'b0);

        txn(8'h22, 0, 40, 16'h5555, 1'b0);

        rr_mode = 1;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) d = $urandom_range(0, 5);
            else if (r == 6) d = $urandom_range(14, 15);
            else if (r == 7) d = $urandom_range(16, 20);
            else d = $urandom_range(0, 3);
            h = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(0, 3);
            txn(8'($urandom), d, h, 16'($urandom), 1'b0);
        end

        rr_mode = 0;
        for (int i = 0; i < 256; i++) begin
            txn(8'($urandom), 40, 0, 16'($urandom), 1'b0);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'(255));

        // Abort a transaction in DATA with an asynchronous reset
        m_d = 100;
        m_hold = 0;
        cur_addr = 8'h55;
        req_addr = 8'h55;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!bus_ds && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_data", 32'(bus_ds), 32'(1));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_as", 32'(bus_as), 32'(0));
        check("mid_rst_ds", 32'(bus_ds), 32'(0));
        check("mid_rst_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_err_cnt", 32'(err_cnt), 32'(0));
        sb.delete();
        seen = 1'b0;
        ecnt_m = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(8'h01, 2, 1, 16'h600D, 1'b0);
        repeat (3) @(negedge clk);
        check("no_stray_rsp", 32'(rsp_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
